// File: rtl/iecdrv_sd_responder_if.sv
// Drive-side SD block bus plus the image-memory byte port seen by the responder.
// The slave modport is the responder; the master modport is the drive/memory environment.
interface iecdrv_sd_responder_if #(
  parameter int MEM_AW = 27
);
  logic [31:0]       sd_lba;
  logic [5:0]        sd_blk_cnt;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [15:0]       sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              oor;

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr,
           mem_wdata, oor
  );

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_wr,
           mem_wdata, oor
  );
endinterface

// File: rtl/iecdrv_sd_responder.sv
// Serves drive sd_rd/sd_wr block requests byte by byte against an image memory.
// Ack one cycle after request; one memory access in flight, stalls on mem_ready.
module iecdrv_sd_responder #(
  parameter int BLK_LOG2 = 9,
  parameter int MEM_AW   = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           img_size,
  iecdrv_sd_responder_if.slave  sd
);
  localparam int FW = 32 + BLK_LOG2;

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, RD_PUT, WR_ADDR, WR_LAT, WR_CAP, WR_WAIT, RELEASE
  } state_t;

  state_t        state;
  logic [31:0]   lba;
  logic [5:0]    blk_cnt;
  logic [15:0]   idx;
  logic [15:0]   idx_nxt;
  logic [15:0]   last;
  logic          at_last;
  logic [FW-1:0] full_addr;
  logic          in_range;

  // Range test uses the untruncated address so images past MEM_AW still clip correctly.
  assign full_addr = (FW'(lba) << BLK_LOG2) + FW'(idx);
  assign in_range  = full_addr < FW'(img_size);
  assign last      = ((16'(blk_cnt) + 16'd1) << BLK_LOG2) - 16'd1;
  assign at_last   = (idx == last);
  assign idx_nxt   = idx + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lba             <= '0;
      blk_cnt         <= '0;
      idx             <= '0;
      sd.sd_ack       <= 1'b0;
      sd.sd_buff_addr <= '0;
      sd.sd_buff_dout <= '0;
      sd.sd_buff_wr   <= 1'b0;
      sd.mem_addr     <= '0;
      sd.mem_rd       <= 1'b0;
      sd.mem_wr       <= 1'b0;
      sd.mem_wdata    <= '0;
      sd.oor          <= 1'b0;
    end else begin
      sd.sd_buff_wr <= 1'b0;
      sd.mem_rd     <= 1'b0;
      sd.mem_wr     <= 1'b0;
      case (state)
        IDLE: begin
          if (sd.sd_rd || sd.sd_wr) begin
            lba       <= sd.sd_lba;
            blk_cnt   <= sd.sd_blk_cnt;
            idx       <= '0;
            sd.oor    <= 1'b0;
            sd.sd_ack <= 1'b1;
            if (sd.sd_rd) begin
              state <= RD_REQ;
            end else begin
              sd.sd_buff_addr <= '0;
              state           <= WR_ADDR;
            end
          end
        end
        RD_REQ: begin
          if (in_range) begin
            sd.mem_addr <= full_addr[MEM_AW-1:0];
            sd.mem_rd   <= 1'b1;
            state       <= RD_WAIT;
          end else begin
            sd.oor          <= 1'b1;
            sd.sd_buff_addr <= idx;
            sd.sd_buff_dout <= 8'h00;
            sd.sd_buff_wr   <= 1'b1;
            state           <= RD_PUT;
          end
        end
        RD_WAIT: begin
          if (sd.mem_ready) begin
            sd.sd_buff_addr <= idx;
            sd.sd_buff_dout <= sd.mem_rdata;
            sd.sd_buff_wr   <= 1'b1;
            state           <= RD_PUT;
          end
        end
        RD_PUT: begin
          if (at_last) begin
            sd.sd_ack <= 1'b0;
            state     <= RELEASE;
          end else begin
            idx   <= idx_nxt;
            state <= RD_REQ;
          end
        end
        WR_ADDR: state <= WR_LAT;
        // The drive's buffer read is registered; din for this address lands in WR_CAP.
        WR_LAT:  state <= WR_CAP;
        WR_CAP: begin
          if (in_range) begin
            sd.mem_addr  <= full_addr[MEM_AW-1:0];
            sd.mem_wdata <= sd.sd_buff_din;
            sd.mem_wr    <= 1'b1;
            state        <= WR_WAIT;
          end else begin
            sd.oor <= 1'b1;
            if (at_last) begin
              sd.sd_ack <= 1'b0;
              state     <= RELEASE;
            end else begin
              idx             <= idx_nxt;
              sd.sd_buff_addr <= idx_nxt;
              state           <= WR_ADDR;
            end
          end
        end
        WR_WAIT: begin
          if (sd.mem_ready) begin
            if (at_last) begin
              sd.sd_ack <= 1'b0;
              state     <= RELEASE;
            end else begin
              idx             <= idx_nxt;
              sd.sd_buff_addr <= idx_nxt;
              state           <= WR_ADDR;
            end
          end
        end
        // A request level still high from the finished transfer must not re-arm us.
        RELEASE: if (!sd.sd_rd && !sd.sd_wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iecdrv_sd_responder.sv
// Directed + randomized bench for iecdrv_sd_responder with an image-memory and track-buffer model.
module tb_iecdrv_sd_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] img_size = 32'd0;

  iecdrv_sd_responder_if #(.MEM_AW(27)) bus ();

  iecdrv_sd_responder #(.BLK_LOG2(9), .MEM_AW(27)) dut (
    .clk      (clk),
    .reset    (reset),
    .img_size (img_size),
    .sd       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [15:0] a; logic [7:0] d; int c;} strobe_t;
  typedef struct {logic [26:0] a; logic [7:0] d;} mwr_t;
  strobe_t     strobe_q[$];
  logic [26:0] rd_q[$];
  mwr_t        wr_q[$];

  bit          pat_addr = 1'b1;
  logic [31:0] mem_key = 32'd0;
  logic [7:0]  sink_key = 8'hFF;
  bit          sink_mix = 1'b0;
  int          lat_min = 2;
  int          lat_max = 2;
  bit          pending = 1'b0;
  int          viol_both = 0;
  int          viol_overlap = 0;
  int          viol_addr_move = 0;

  function automatic logic [7:0] mem_val(input logic [26:0] a);
    if (pat_addr) return a[7:0];
    return 8'((32'(a) * 32'd37) ^ (32'(a) >> 8) ^ mem_key);
  endfunction

  function automatic logic [7:0] sink_val(input logic [15:0] a);
    return a[7:0] ^ sink_key ^ (sink_mix ? a[15:8] : 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Image memory: one outstanding access, response after a random latency (>= 1 cycle).
  initial begin
    int          resp_cnt;
    logic [7:0]  rdv;
    logic [15:0] prev_baddr;
    resp_cnt = 0;
    rdv = 8'h00;
    prev_baddr = 16'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      if (bus.sd_buff_addr !== prev_baddr && pending && !reset) viol_addr_move++;
      prev_baddr = bus.sd_buff_addr;
      if (bus.sd_buff_wr === 1'b1)
        strobe_q.push_back('{a: bus.sd_buff_addr, d: bus.sd_buff_dout, c: cyc});
      if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) viol_both++;
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
        if (pending) viol_overlap++;
        pending = 1'b1;
        resp_cnt = $urandom_range(lat_max, lat_min);
        if (bus.mem_rd === 1'b1) begin
          rd_q.push_back(bus.mem_addr);
          rdv = mem_val(bus.mem_addr);
        end else begin
          wr_q.push_back('{a: bus.mem_addr, d: bus.mem_wdata});
        end
      end else if (pending) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          pending = 1'b0;
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rdv;
        end
      end
    end
  end

  // Track buffer: din reflects the address presented two cycles earlier.
  initial begin
    logic [15:0] a1, a2;
    a1 = 16'h0;
    a2 = 16'h0;
    bus.sd_buff_din = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus.sd_buff_din = sink_val(a2);
      a2 = a1;
      a1 = bus.sd_buff_addr;
    end
  end

  // kind: 0 read, 1 write, 2 both requests high (read wins).
  task automatic do_xfer(input int kind, input logic [31:0] lba, input logic [5:0] cnt,
                         input logic [31:0] img, input bit hold, input string tag);
    int          n, last, nerr, nin;
    int          ack_fall_cyc;
    logic [63:0] a;
    bit          inr, exp_oor;
    logic [7:0]  ed;
    strobe_q.delete();
    rd_q.delete();
    wr_q.delete();
    img_size = img;
    bus.sd_lba = lba;
    bus.sd_blk_cnt = cnt;
    bus.sd_rd = (kind != 1);
    bus.sd_wr = (kind != 0);
    @(posedge clk); #1;
    chk({tag, "/ack_rise"}, bus.sd_ack, 1);
    if (!hold) begin
      bus.sd_rd = 1'b0;
      bus.sd_wr = 1'b0;
    end
    bus.sd_lba = $urandom;
    bus.sd_blk_cnt = 6'($urandom);
    n = 0;
    while (bus.sd_ack === 1'b1 && n < 60000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/done_in_budget"}, (n < 60000), 1);
    ack_fall_cyc = cyc;

    last = ((int'(cnt) + 1) * 512) - 1;
    exp_oor = 1'b0;
    nerr = 0;
    nin = 0;
    for (int i = 0; i <= last; i++) begin
      a = (64'(lba) << 9) + 64'(i);
      inr = (a < 64'(img));
      if (!inr) exp_oor = 1'b1;
      if (kind != 1) begin
        ed = inr ? mem_val(a[26:0]) : 8'h00;
        if (i >= strobe_q.size()) nerr++;
        else if (strobe_q[i].a !== 16'(i) || strobe_q[i].d !== ed) nerr++;
        if (inr) begin
          if (nin >= rd_q.size() || rd_q[nin] !== a[26:0]) nerr++;
          nin++;
        end
      end else if (inr) begin
        if (nin >= wr_q.size() || wr_q[nin].a !== a[26:0] || wr_q[nin].d !== sink_val(16'(i))) nerr++;
        nin++;
      end
    end
    if (kind != 1) begin
      chk({tag, "/strobe_count"}, strobe_q.size(), last + 1);
      chk({tag, "/mem_rd_count"}, rd_q.size(), nin);
      chk({tag, "/no_mem_wr"}, wr_q.size(), 0);
      if (strobe_q.size() > 0) chk({tag, "/ack_fall"}, ack_fall_cyc, strobe_q[$].c + 1);
    end else begin
      chk({tag, "/mem_wr_count"}, wr_q.size(), nin);
      chk({tag, "/no_strobe"}, strobe_q.size(), 0);
      chk({tag, "/no_mem_rd"}, rd_q.size(), 0);
    end
    chk({tag, "/data_errors"}, nerr, 0);
    chk({tag, "/oor"}, bus.oor, exp_oor);
    if (!hold) repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n, ns, hi;
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    bus.sd_lba = 32'd0;
    bus.sd_blk_cnt = 6'd0;
    mem_key = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/sd_ack", bus.sd_ack, 0);
    chk("rst/sd_buff_wr", bus.sd_buff_wr, 0);
    chk("rst/mem_rd", bus.mem_rd, 0);
    chk("rst/mem_wr", bus.mem_wr, 0);
    chk("rst/oor", bus.oor, 0);
    chk("rst/sd_buff_addr", bus.sd_buff_addr, 0);
    chk("rst/mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Address-pattern memory, fixed 2-cycle latency.
    do_xfer(0, 32'd3, 6'd0, 32'h0010_0000, 1'b0, "rd_lba3");
    do_xfer(1, 32'd0, 6'd1, 32'h0010_0000, 1'b0, "wr_lba0");

    pat_addr = 1'b0;
    lat_min = 1;
    lat_max = 3;
    do_xfer(0, 32'd1, 6'd1, 32'd700, 1'b0, "rd_img700");

    // Both requests high, then held across completion.
    do_xfer(2, 32'($urandom_range(0, 20)), 6'd0, 32'h0010_0000, 1'b1, "both");
    ns = rd_q.size();
    hi = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.sd_ack !== 1'b0) hi++;
    end
    chk("hold/no_rearm_ack", hi, 0);
    chk("hold/no_new_mem_rd", rd_q.size(), ns);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    @(posedge clk); #1;
    do_xfer(0, 32'd7, 6'd0, 32'h0010_0000, 1'b0, "rd_after_drop");

    // Reset while the read for idx 100 is outstanding.
    lat_min = 10;
    lat_max = 10;
    strobe_q.delete();
    rd_q.delete();
    wr_q.delete();
    img_size = 32'h0010_0000;
    bus.sd_lba = 32'd5;
    bus.sd_blk_cnt = 6'd0;
    bus.sd_rd = 1'b1;
    @(posedge clk); #1;
    bus.sd_rd = 1'b0;
    n = 0;
    while (rd_q.size() < 101 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst/reached_idx100", (rd_q.size() == 101), 1);
    chk("midrst/strobes_before", strobe_q.size(), 100);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst/sd_ack", bus.sd_ack, 0);
    chk("midrst/sd_buff_wr", bus.sd_buff_wr, 0);
    chk("midrst/mem_rd", bus.mem_rd, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ns = strobe_q.size();
    n = 0;
    while (pending && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst/late_ready_delivered", pending, 0);
    chk("midrst/late_ready_ignored", strobe_q.size(), ns);
    chk("midrst/ack_idle", bus.sd_ack, 0);
    chk("midrst/no_new_mem_rd", rd_q.size(), 101);
    lat_min = 1;
    lat_max = 3;
    do_xfer(0, 32'd5, 6'd0, 32'h0010_0000, 1'b0, "rd_after_rst");

    // Slow memory on the write path.
    lat_min = 20;
    lat_max = 20;
    sink_key = 8'($urandom);
    sink_mix = 1'b1;
    do_xfer(1, 32'd2, 6'd0, 32'h0010_0000, 1'b0, "wr_slow");
    chk("wr_slow/addr_moved_while_pending", viol_addr_move, 0);

    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 3; k++) begin
      mem_key = $urandom;
      sink_key = 8'($urandom);
      do_xfer(int'($urandom_range(0, 1)), 32'($urandom_range(0, 8)), 6'($urandom_range(0, 1)),
              32'($urandom_range(0, 5000)), 1'b0, $sformatf("rand%0d", k));
    end

    chk("inv/mem_rd_wr_together", viol_both, 0);
    chk("inv/overlapping_access", viol_overlap, 0);
    chk("inv/addr_moved_while_pending", viol_addr_move, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
